// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
// The state encoding is also exported on the top-level debug port.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

  localparam int REP_W = 4;
  localparam int GAP_W = 4;

  // A requested length of 0, or one longer than the register, means "send all WIDTH bits".
  function automatic int eff_len(input int len, input int width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_shift.sv
// Loadable left-shift register with a bit down-counter.
// The pattern is left-aligned on load so the MSB of the register is always the next bit.
module seq_shift_out #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o,
  output logic             last_o
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(WIDTH);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sh_d  = data_i << (LEN_MAX - len_i);
      cnt_d = len_i - LEN_ONE;
    end else if (shift_i) begin
      sh_d = {sh_q[WIDTH-2:0], 1'b0};
      if (cnt_q != '0) begin
        cnt_d = cnt_q - LEN_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_o  = sh_q[WIDTH-1];
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a pattern word, shifts it out MSB-first,
// optionally repeating it with an idle gap between repetitions.
//
// Handshake: a pattern is taken on any rising edge where in_valid && in_ready;
// in_ready is high only in IDLE, so in_valid while busy is ignored and the
// requester must keep in_valid (and the pattern fields) stable until taken.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LEN_W      = $clog2(WIDTH + 1),
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic [3:0]       in_repeat,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             done_q, done_d;

  logic             sh_load, sh_shift, sh_bit, sh_last;
  logic [WIDTH-1:0] sh_data;
  logic [LEN_W-1:0] sh_len;
  logic [LEN_W-1:0] in_len_eff;

  assign in_len_eff = LEN_W'(eff_len(int'(in_len), WIDTH));

  seq_shift_out #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .len_i   (sh_len),
    .data_i  (sh_data),
    .bit_o   (sh_bit),
    .last_o  (sh_last)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    len_d    = len_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = pat_q;
    sh_len   = len_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pat_d   = in_data;
          len_d   = in_len_eff;
          rep_d   = in_repeat;
          sh_load = 1'b1;
          sh_data = in_data;
          sh_len  = in_len_eff;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!sh_last) begin
          sh_shift = 1'b1;
        end else if (rep_q != '0) begin
          rep_d = rep_q - REP_ONE;
          // With no gap the reload lands on the same edge, so bits stay back-to-back.
          if (GAP_CYCLES == 0) begin
            sh_load = 1'b1;
          end else begin
            gap_d   = GAP_LOAD;
            state_d = GAP;
          end
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          sh_load = 1'b1;
          state_d = SEND;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
    end
  end

  // All outputs decode straight from flops; w is masked so it reads 0 outside SEND.
  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign w_valid     = (state_q == SEND);
  assign w           = (state_q == SEND) && sh_bit;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a per-cycle expectation queue built
// from the pattern rules, directed scenarios, then a randomized soak.
module tb_seq_pattern_tx;

  localparam int WIDTH = 8;
  localparam int LEN_W = $clog2(WIDTH + 1);
  localparam int GAPC  = 2;

  // Expected-output vector layout: {w_valid, w, done, busy, in_ready}
  localparam logic [4:0] IDLE_V = 5'b00001;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic [3:0]       in_repeat;
  logic             w, w_valid, busy, done;
  logic [1:0]       dbg_state;

  seq_pattern_tx #(
    .WIDTH      (WIDTH),
    .LEN_W      (LEN_W),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_len      (in_len),
    .in_repeat   (in_repeat),
    .w           (w),
    .w_valid     (w_valid),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [4:0]  exp_q[$];
  logic [4:0]  cur_exp;
  logic        cur_ready = 1'b0;
  logic        accepted  = 1'b0;
  int          cyc       = 0;
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          z_cnt     = 0;
  logic        prev_one  = 1'b0;
  logic [31:0] cap       = '0;
  int          cap_n     = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endfunction

  // Reference: the whole output trace of one pattern, written as a list of cycles.
  function automatic void push_pattern(input logic [WIDTH-1:0] d, input int len, input int rep);
    int l;
    l = ((len == 0) || (len > WIDTH)) ? WIDTH : len;
    for (int r = 0; r <= rep; r++) begin
      for (int i = l - 1; i >= 0; i--) exp_q.push_back({1'b1, d[i], 1'b0, 1'b1, 1'b0});
      if (r < rep) for (int g = 0; g < GAPC; g++) exp_q.push_back(5'b00010);
    end
    exp_q.push_back(5'b00101);
  endfunction

  // One clock: decide acceptance for the coming edge, then compare after it.
  task automatic step();
    accepted = 1'b0;
    if (reset) exp_q.delete();
    else if (in_valid && cur_ready) begin
      push_pattern(in_data, int'(in_len), int'(in_repeat));
      accepted = 1'b1;
    end
    @(negedge clk);
    cyc++;
    cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE_V;
    chk("outputs", {27'd0, w_valid, w, done, busy, in_ready}, {27'd0, cur_exp});
    cur_ready = cur_exp[0];
    if (w_valid && w && prev_one) z_cnt++;
    prev_one = w_valid && w;
    if (w_valid) begin
      cap = {cap[30:0], w};
      cap_n++;
    end
  endtask

  // driver: present a pattern and hold it until taken; k = accept edge index
  task automatic send(input logic [WIDTH-1:0] d, input logic [LEN_W-1:0] l,
                      input logic [3:0] r, output int k);
    in_valid  = 1'b1;
    in_data   = d;
    in_len    = l;
    in_repeat = r;
    k = -1;
    for (int t = 0; t < 300; t++) begin
      step();
      if (accepted) begin
        k = cyc - 1;
        break;
      end
    end
    if (k < 0) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int k, output int lat);
    lat = -1;
    for (int t = 0; t < 300; t++) begin
      step();
      if (done === 1'b1) begin
        lat = cyc - k;
        break;
      end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_capture();
    cap = '0;
    cap_n = 0;
    z_cnt = 0;
  endtask

  int k_a, k_b, lat;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; in_repeat = '0;

    // 1: reset held with in_valid high
    step();
    in_valid = 1'b1; in_data = 8'h5A; in_len = 4'd8;
    repeat (3) step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    step();

    // 2: full-width pattern, no repeat
    clear_capture();
    send(8'b1011_0110, 4'd8, 4'd0, k_a);
    in_valid = 1'b0;
    wait_done(k_a, lat);
    chk("t2_latency", lat, 32'd9);
    chk("t2_bits", cap, 32'b1011_0110);
    chk("t2_nbits", cap_n, 32'd8);
    chk("t2_z_count", z_cnt, 32'd2);
    step();

    // 3: short pattern with repeats and gaps
    clear_capture();
    send(8'b0000_0011, 4'd2, 4'd2, k_a);
    in_valid = 1'b0;
    wait_done(k_a, lat);
    chk("t3_latency", lat, 32'd11);
    chk("t3_nbits", cap_n, 32'd6);
    chk("t3_z_count", z_cnt, 32'd3);
    step();

    // 4: zero length means full width
    clear_capture();
    send(8'hFF, 4'd0, 4'd0, k_a);
    in_valid = 1'b0;
    wait_done(k_a, lat);
    chk("t4_nbits", cap_n, 32'd8);
    chk("t4_z_count", z_cnt, 32'd7);
    step();

    // 5: reset mid-SEND, then a clean pattern
    send(8'hF0, 4'd8, 4'd0, k_a);
    in_valid = 1'b0;
    while (cyc < k_a + 4) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_done", {31'd0, done}, 32'd0);
    clear_capture();
    send(8'hA5, 4'd8, 4'd0, k_a);
    in_valid = 1'b0;
    wait_done(k_a, lat);
    chk("t5_latency", lat, 32'd9);
    chk("t5_bits", cap, 32'hA5);
    step();

    // 6: in_valid held across two patterns
    send(8'h0D, 4'd4, 4'd0, k_a);
    send(8'h03, 4'd2, 4'd1, k_b);
    in_valid = 1'b0;
    chk("t6_accept_spacing", k_b - k_a, 32'd5);
    wait_done(k_b, lat);
    chk("t6_latency", lat, 32'd7);

    // random soak: arbitrary requests, occasional reset
    for (int t = 0; t < 1500; t++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = WIDTH'($urandom());
      in_len    = LEN_W'($urandom_range(0, 15));
      in_repeat = 4'($urandom_range(0, 3));
      step();
    end
    reset = 1'b0; in_valid = 1'b0;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) step();
    chk("drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial pattern transmitter that produces the single-bit `w` stream consumed by the team's serial sequence detectors.
- Accepts a parallel pattern word through a valid/ready handshake.
- Shifts the pattern out MSB-first, one bit per clock.
- Optionally repeats the pattern, with an idle gap between repetitions.
- Sits between the test/control logic and any FSM that samples `w` on `clk`.

Parameters:
WIDTH, 8, maximum pattern length in bits (2..32)
LEN_W, $clog2(WIDTH+1), width of the in_len field
GAP_CYCLES, 2, idle cycles (w_valid=0, w=0) inserted between repetitions (0..15)

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  pattern request valid
in_ready  output  1  block can accept a pattern
in_data  input  WIDTH  pattern; bit in_len-1 is sent first
in_len  input  LEN_W  number of bits to send; 0 or >WIDTH treated as WIDTH
in_repeat  input  4  extra repetitions; total sends = in_repeat+1
w  output  1  serial bit out, registered
w_valid  output  1  w carries a pattern bit this cycle
busy  output  1  high in SEND and GAP
done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Reset (synchronous, sampled on the clk edge):
  - state=IDLE; w=0, w_valid=0, busy=0, done=0, in_ready=1.
  - Counters and shift register cleared.
  - Reset asserted mid-SEND or mid-GAP aborts immediately: no done pulse, and the pattern is lost.
- States:
  - IDLE: in_ready=1.
  - SEND: emits bits.
  - GAP: idle spacing between repetitions.
- Accept:
  - A handshake occurs when in_valid && in_ready at edge k.
  - On accept, latch in_data, the effective length L, and the repeat count R.
  - Go to SEND; in_ready=0 from cycle k+1.
- SEND:
  - Cycle k+1 outputs w=in_data[L-1] with w_valid=1.
  - Each following cycle outputs the next lower bit; bit 0 is output at cycle k+L.
  - Sourced from a registered shift register, so outputs are glitch-free.
- End of a repetition:
  - If repetitions remain, go to GAP for GAP_CYCLES cycles (w=0, w_valid=0), reload the latched pattern, then return to SEND.
  - If GAP_CYCLES=0, SEND re-enters directly, giving back-to-back bits with no bubble.
- Completion:
  - After the last bit of the last repetition, enter IDLE.
  - done=1 and in_ready=1 in that same cycle, k+L+1 for R=0.
  - w_valid=0 and w=0 in IDLE.
- Back-to-back patterns: a new accept is allowed in the done cycle; its first bit appears in the next cycle. Minimum spacing between patterns is therefore one idle cycle.
- in_valid while busy: ignored (in_ready=0). The requester must hold in_valid until accepted.
- Total w_valid cycles per pattern = L*(R+1).
- Total latency from accept to done = L*(R+1) + GAP_CYCLES*R + 1.
- L=1: single-bit pattern; SEND lasts one cycle per repetition.

Decomposition:
- Package seq_tx_pkg holds:
  - state encoding localparams IDLE=2'd0, SEND=2'd1, GAP=2'd2;
  - the effective-length function (0 or >WIDTH → WIDTH).
- One sub-module, seq_shift_out: a loadable left-shift register plus down-counter.
  - Inputs: load, len, data.
  - Outputs: bit, last.
- The top level holds the FSM, repeat and gap counters, and the handshake.

Test Plan:
1. Reset, then hold reset 3 cycles with in_valid=1 → in_ready=1, w_valid=0, no accept, done never high.
2. in_data=8'b1011_0110, in_len=8, in_repeat=0 → w=1,0,1,1,0,1,1,0 in cycles k+1..k+8, w_valid=1 throughout; done=1 at k+9. A Mealy "two consecutive 1s" detector driven by w pulses z exactly 2 times.
3. in_data=8'b0000_0011, in_len=2, in_repeat=2, GAP_CYCLES=2 → w: 1,1,gap,gap,1,1,gap,gap,1,1; 6 valid bits; done at k+11.
4. in_len=0, in_data=8'hFF → 8 ones sent (length treated as WIDTH); detector z high for 7 consecutive cycles.
5. Accept pattern A, assert reset at k+4 → next cycle w_valid=0, busy=0, in_ready=1, no done. Then submit pattern B (8'hA5, len 8) → B is sent complete and correct.
6. Two patterns, with in_valid held continuously → second accept occurs in the first pattern's done cycle; its first bit appears one cycle later. in_valid asserted mid-SEND is never accepted early.
